// File: rtl/sfp_norm_row_pkg.sv
// Shared widths and FSM encoding for the SFP normalisation row.
package sfp_norm_row_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_ITER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Row abs-sum width: one psum plus growth for COL terms
  function automatic int unsigned sfp_sw(input int unsigned bw_psum, input int unsigned col);
    return bw_psum + $clog2(col);
  endfunction

  // Divisor width after adding two sums and dropping SHIFT LSBs
  function automatic int unsigned sfp_dw(input int unsigned sw, input int unsigned shift);
    return sw + 1 - shift;
  endfunction

  // Numerator / quotient width (magnitude with fractional bits appended)
  function automatic int unsigned sfp_nb(input int unsigned bw_psum, input int unsigned frac);
    return bw_psum + frac;
  endfunction

endpackage

// File: rtl/sfp_norm_row_sum_fifo.sv
// Show-ahead sum FIFO; a pop and push on the same cycle both succeed, even when full.
module sfp_norm_row_sum_fifo #(
  parameter int unsigned BW    = 23,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [BW-1:0] wdata,
  input  logic          pop,
  output logic [BW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [BW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[AW'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sfp_norm_row.sv
// SFP row: accumulates abs-sums into two FIFOs and normalises a row by the
// local (+ optional peer) sum using COL serial restoring dividers.
module sfp_norm_row
  import sfp_norm_row_pkg::*;
#(
  parameter  int unsigned COL     = 8,
  parameter  int unsigned BW_PSUM = 20,
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned FRAC    = 8,
  parameter  int unsigned SHIFT   = 7,
  localparam int unsigned SW      = sfp_sw(BW_PSUM, COL)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc,
  input  logic                   div_start,
  input  logic                   ext_en,
  input  logic [COL*BW_PSUM-1:0] sfp_in,
  input  logic [SW-1:0]          sum_in,
  input  logic                   ext_rd,
  output logic [SW-1:0]          sum_out,
  output logic                   sum_out_valid,
  output logic [COL*BW_PSUM-1:0] sfp_out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   div_zero,
  output logic                   ovf
);

  localparam int unsigned DW = sfp_dw(SW, SHIFT);
  localparam int unsigned NB = sfp_nb(BW_PSUM, FRAC);
  localparam int unsigned CW = $clog2(NB);
  localparam logic [BW_PSUM-1:0] Q_MAX = {1'b0, {(BW_PSUM-1){1'b1}}};
  localparam logic [BW_PSUM-1:0] Q_MIN = {1'b1, {(BW_PSUM-1){1'b0}}};

  function automatic logic [BW_PSUM-1:0] mag(input logic [BW_PSUM-1:0] x);
    return x[BW_PSUM-1] ? -x : x;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [SW-1:0]          acc_sum_c, acc_sum_q;
  logic                   push_q;
  logic [SW-1:0]          int_head;
  logic                   int_full, int_empty, int_pop;
  logic                   ext_empty, ext_full_unused;
  logic [SW:0]            dsum_c;
  logic [DW-1:0]          div_c, div_q;
  logic [CW-1:0]          cnt_q;
  logic [COL*BW_PSUM-1:0] row_q;
  logic [COL*BW_PSUM-1:0] res_flat_c;

  // Row abs-sum; SW bits cannot overflow for COL terms
  always_comb begin
    acc_sum_c = '0;
    for (int unsigned k = 0; k < COL; k++)
      acc_sum_c = acc_sum_c + SW'(mag(sfp_in[k*BW_PSUM +: BW_PSUM]));
  end

  sfp_norm_row_sum_fifo #(.BW(SW), .DEPTH(DEPTH)) u_int_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .wdata (acc_sum_q),
    .pop   (int_pop),
    .rdata (int_head),
    .full  (int_full),
    .empty (int_empty)
  );

  sfp_norm_row_sum_fifo #(.BW(SW), .DEPTH(DEPTH)) u_ext_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_q),
    .wdata (acc_sum_q),
    .pop   (ext_rd),
    .rdata (sum_out),
    .full  (ext_full_unused),
    .empty (ext_empty)
  );

  assign sum_out_valid = !ext_empty;
  assign int_pop       = (state_q == ST_LOAD);
  assign dsum_c        = (SW+1)'(int_head) + (SW+1)'(ext_en ? sum_in : SW'(0));
  assign div_c         = DW'(dsum_c >> SHIFT);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; div_start is only heard in IDLE with a sum available
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (div_start && !int_empty) state_d = ST_LOAD;
      ST_LOAD: state_d = (div_c == '0) ? ST_DONE : ST_ITER;
      ST_ITER: if (cnt_q == '0) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Divider lanes; row_q is stable for the whole division
  for (genvar k = 0; k < COL; k++) begin : g_lane
    logic [BW_PSUM-1:0] x;
    logic [NB-1:0]      num_q;
    logic [NB-2:0]      quo_q;
    logic [DW-1:0]      rem_q;
    logic [DW:0]        shl, diff;
    logic [NB-1:0]      quo_c;
    logic [BW_PSUM-1:0] qsat, res;

    assign x     = row_q[k*BW_PSUM +: BW_PSUM];
    assign shl   = {rem_q, num_q[NB-1]};
    assign diff  = shl - {1'b0, div_q};
    assign quo_c = {quo_q, ~diff[DW]};

    always_comb begin
      qsat = (quo_c > NB'(Q_MAX)) ? Q_MAX : quo_c[BW_PSUM-1:0];
      if (state_q == ST_LOAD) res = (x == '0) ? '0 : (x[BW_PSUM-1] ? Q_MIN : Q_MAX);
      else                    res = x[BW_PSUM-1] ? -qsat : qsat;
    end

    assign res_flat_c[k*BW_PSUM +: BW_PSUM] = res;

    always_ff @(posedge clk) begin
      if (reset) begin
        num_q <= '0;
        quo_q <= '0;
        rem_q <= '0;
      end else if (state_q == ST_LOAD) begin
        num_q <= {mag(x), FRAC'(0)};
        quo_q <= '0;
        rem_q <= '0;
      end else if (state_q == ST_ITER) begin
        num_q <= num_q << 1;
        quo_q <= quo_c[NB-2:0];
        rem_q <= diff[DW] ? shl[DW-1:0] : diff[DW-1:0];
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_sum_q <= '0;
      push_q    <= 1'b0;
      row_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      sfp_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      push_q <= acc;
      if (acc) acc_sum_q <= acc_sum_c;
      if (state_q == ST_IDLE && state_d == ST_LOAD) row_q <= sfp_in;
      if (state_q == ST_LOAD) begin
        div_q <= div_c;
        cnt_q <= CW'(NB-1);
      end else if (state_q == ST_ITER) begin
        cnt_q <= cnt_q - CW'(1);
      end
      out_valid <= (state_d == ST_DONE);
      busy      <= (state_d != ST_IDLE);
      div_zero  <= (state_q == ST_LOAD) && (state_d == ST_DONE);
      if (state_d == ST_DONE) sfp_out <= res_flat_c;
      if (push_q && int_full && !int_pop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sfp_norm_row.sv
// Scoreboard bench for sfp_norm_row: directed rows with hand-computed results.
module tb_sfp_norm_row;

  localparam int unsigned COL = 8;
  localparam int unsigned BW  = 20;
  localparam int unsigned SW  = 23;
  localparam int          NB  = 28;

  logic              clk = 1'b0;
  logic              reset;
  logic              acc, div_start, ext_en, ext_rd;
  logic [COL*BW-1:0] sfp_in;
  logic [SW-1:0]     sum_in;
  logic [SW-1:0]     sum_out;
  logic              sum_out_valid;
  logic [COL*BW-1:0] sfp_out;
  logic              out_valid, busy, div_zero, ovf;

  typedef struct {
    logic [COL*BW-1:0] data;
    logic              dz;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  sfp_norm_row dut (
    .clk           (clk),
    .reset         (reset),
    .acc           (acc),
    .div_start     (div_start),
    .ext_en        (ext_en),
    .sfp_in        (sfp_in),
    .sum_in        (sum_in),
    .ext_rd        (ext_rd),
    .sum_out       (sum_out),
    .sum_out_valid (sum_out_valid),
    .sfp_out       (sfp_out),
    .out_valid     (out_valid),
    .busy          (busy),
    .div_zero      (div_zero),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [COL*BW-1:0] act, input logic [COL*BW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [COL*BW-1:0] row8(input int a0, input int a1, input int a2, input int a3,
                                             input int a4, input int a5, input int a6, input int a7);
    return {20'(a7), 20'(a6), 20'(a5), 20'(a4), 20'(a3), 20'(a2), 20'(a1), 20'(a0)};
  endfunction

  // Reference for one lane: |x|*256 / d, saturated, sign restored
  function automatic logic [BW-1:0] exp_lane(input int x, input int d);
    longint n, q;
    n = longint'(x < 0 ? -x : x) * 256;
    if (d == 0) return (n == 0) ? 20'h0 : (x < 0 ? 20'h80000 : 20'h7FFFF);
    q = n / d;
    if (q > 524287) q = 524287;
    return (x < 0) ? 20'(-q) : 20'(q);
  endfunction

  // Monitor: every out_valid must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 160'(out_valid), 160'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sfp_out", sfp_out, e.data);
          chk("div_zero", 160'(div_zero), 160'(e.dz));
          chk("latency_cyc", 160'(cyc), 160'(e.cyc));
        end
      end else if (div_zero) begin
        chk("div_zero_without_valid", 160'(div_zero), 160'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // acc pulse, then one more cycle so the sum lands in both FIFOs
  task automatic do_acc(input logic [COL*BW-1:0] row);
    sfp_in = row;
    acc    = 1'b1;
    tick();
    acc = 1'b0;
    tick();
  endtask

  task automatic do_div(input logic [COL*BW-1:0] row, input logic ee, input int si,
                        input logic [COL*BW-1:0] expd, input logic dz, input int lat);
    exp_t e;
    sfp_in    = row;
    ext_en    = ee;
    sum_in    = SW'(si);
    div_start = 1'b1;
    e.data = expd;
    e.dz   = dz;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
    tick();
    div_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("pending_after_wait", 160'(exp_q.size()), 160'(0));
  endtask

  initial begin
    logic [COL*BW-1:0] r256, rmix, expd;
    int vals[8];
    acc = 0; div_start = 0; ext_en = 0; ext_rd = 0; sfp_in = '0; sum_in = '0;
    reset = 1'b1;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    chk("rst_sfp_out", sfp_out, '0);
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_div_zero", 160'(div_zero), 160'(0));
    chk("rst_ovf", 160'(ovf), 160'(0));
    chk("rst_sum_out_valid", 160'(sum_out_valid), 160'(0));
    chk("rst_sum_out", 160'(sum_out), 160'(0));

    // 1: all 256, sum 2048, D=16 -> 4096
    r256 = row8(256, 256, 256, 256, 256, 256, 256, 256);
    do_acc(r256);
    do_div(r256, 1'b0, 0, row8(4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096), 1'b0, NB + 2);
    chk("busy_during_div", 160'(busy), 160'(1));
    wait_done();

    // 2: col0 negative
    rmix = row8(-256, 256, 256, 256, 256, 256, 256, 256);
    do_acc(rmix);
    do_div(rmix, 1'b0, 0, row8(-4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096), 1'b0, NB + 2);
    wait_done();

    // 3: peer sum doubles the divisor; ext FIFO head visible until popped
    do_rst();
    do_acc(r256);
    chk("ext_head", 160'(sum_out), 160'(2048));
    chk("ext_valid", 160'(sum_out_valid), 160'(1));
    do_div(r256, 1'b1, 2048, row8(2048, 2048, 2048, 2048, 2048, 2048, 2048, 2048), 1'b0, NB + 2);
    wait_done();
    chk("ext_head_kept", 160'(sum_out), 160'(2048));
    ext_rd = 1'b1;
    tick();
    ext_rd = 1'b0;
    chk("ext_valid_after_pop", 160'(sum_out_valid), 160'(0));
    ext_rd = 1'b1;
    tick();
    ext_rd = 1'b0;
    chk("ext_valid_rd_empty", 160'(sum_out_valid), 160'(0));

    // 4: divide by zero cases
    do_acc('0);
    do_div('0, 1'b0, 0, '0, 1'b1, 2);
    wait_done();
    do_acc(row8(5, -5, 0, 0, 0, 0, 0, 0));
    do_div(row8(5, -5, 0, 0, 0, 0, 0, 0), 1'b1, 0, row8(524287, -524288, 0, 0, 0, 0, 0, 0), 1'b1, 2);
    wait_done();

    // 5: 17 pushes overflow the internal FIFO; sums i*128 give D=i in order
    do_rst();
    for (int i = 1; i <= 17; i++) begin
      sfp_in = row8(i * 128, 0, 0, 0, 0, 0, 0, 0);
      acc    = 1'b1;
      tick();
    end
    acc = 1'b0;
    tick();
    tick();
    chk("ovf_sticky", 160'(ovf), 160'(1));
    chk("ext_head_first", 160'(sum_out), 160'(128));
    vals = '{3000, -3000, 1000, -1000, 7, 0, -524288, 524287};
    for (int i = 1; i <= 16; i++) begin
      for (int k = 0; k < 8; k++) expd[k*BW +: BW] = exp_lane(vals[k], i);
      do_div(row8(vals[0], vals[1], vals[2], vals[3], vals[4], vals[5], vals[6], vals[7]),
             1'b0, 0, expd, 1'b0, NB + 2);
      wait_done();
    end
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    tick();
    chk("div_start_empty_ignored", 160'(busy), 160'(0));
    chk("ovf_still_set", 160'(ovf), 160'(1));

    // 6: reset in the middle of an iteration
    do_rst();
    do_acc(r256);
    do_div(r256, 1'b0, 0, row8(4096, 4096, 4096, 4096, 4096, 4096, 4096, 4096), 1'b0, NB + 2);
    wait_done();
    do_acc(r256);
    sfp_in    = r256;
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    repeat (11) tick();
    chk("busy_mid_iter", 160'(busy), 160'(1));
    reset = 1'b1;
    tick();
    chk("busy_after_reset", 160'(busy), 160'(0));
    chk("sfp_out_after_reset", sfp_out, '0);
    reset = 1'b0;
    chk("ext_empty_after_reset", 160'(sum_out_valid), 160'(0));
    repeat (40) tick();
    div_start = 1'b1;
    tick();
    div_start = 1'b0;
    tick();
    chk("int_empty_after_reset", 160'(busy), 160'(0));

    chk("scoreboard_drained", 160'(exp_q.size()), 160'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout: got cyc %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
